// File: rtl/osd_event_sample_fifo_if.sv
// Sample-capture and packetizer word-request bundle; slave = sample FIFO, master = feeder/packetizer side.
// Width parameters mirror the FIFO's derived word count so both ends agree on index and count widths.
interface osd_event_sample_fifo_if #(
    parameter int WIDTH = 64
);
    localparam int MAX_DATA_NUM_WORDS = (WIDTH + 15) / 16;
    localparam int NUMW_W = $clog2(MAX_DATA_NUM_WORDS + 1);
    localparam int IDX_W  = (MAX_DATA_NUM_WORDS > 1) ? $clog2(MAX_DATA_NUM_WORDS) : 1;

    logic              sample_valid;
    logic [WIDTH-1:0]  sample_data;
    logic              event_available;
    logic              event_consumed;
    logic              overflow;
    logic [NUMW_W-1:0] data_num_words;
    logic [IDX_W-1:0]  data_req_idx;
    logic              data_req_valid;
    logic [15:0]       data;

    modport slave (
        input  sample_valid, sample_data, event_consumed, data_req_idx, data_req_valid,
        output event_available, overflow, data_num_words, data
    );

    modport master (
        output sample_valid, sample_data, event_consumed, data_req_idx, data_req_valid,
        input  event_available, overflow, data_num_words, data
    );
endinterface

// File: rtl/osd_event_sample_fifo.sv
// Trace sample FIFO feeding the packetizer; one-cycle push-to-available latency, head words read combinationally.
// No input backpressure: samples arriving while full are dropped, counted, and later re-inserted as an overflow event.
module osd_event_sample_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    osd_event_sample_fifo_if.slave  bus
);
    localparam int NW     = (WIDTH + 15) / 16;
    localparam int PW     = 16 * NW;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int NUMW_W = $clog2(NW + 1);

    typedef struct packed {
        logic             ov;
        logic [WIDTH-1:0] pay;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       ov_cnt_q, ov_cnt_d;

    logic              full, empty, push, pop;
    entry_t            wr_entry, head;
    logic [PW-1:0]     ov_pay, head_pay;
    logic              head_ov;
    logic [NUMW_W-1:0] num_words;
    logic [15:0]       rd_word;
    logic              unused_req_vld;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full   = (cnt_q == CNT_W'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign pop    = bus.event_consumed && !empty;
    assign ov_pay = PW'(ov_cnt_q);
    assign unused_req_vld = bus.data_req_valid;

    // A pending drop count always claims the free slot first so the overflow
    // marker lands exactly where the gap in the sample stream occurred.
    always_comb begin
        push     = 1'b0;
        wr_entry = '0;
        ov_cnt_d = ov_cnt_q;
        if (ov_cnt_q != 16'd0 && !full) begin
            push         = 1'b1;
            wr_entry.ov  = 1'b1;
            wr_entry.pay = ov_pay[WIDTH-1:0];
            ov_cnt_d     = bus.sample_valid ? 16'd1 : 16'd0;
        end else if (bus.sample_valid && !full) begin
            push         = 1'b1;
            wr_entry.pay = bus.sample_data;
        end else if (bus.sample_valid && full && ov_cnt_q != 16'hFFFF) begin
            ov_cnt_d = ov_cnt_q + 16'd1;
        end
    end

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ov_cnt_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ov_cnt_q <= ov_cnt_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign head_pay  = PW'(head.pay);
    assign head_ov   = head.ov & !empty;
    assign num_words = empty ? '0 : (head_ov ? NUMW_W'(1) : NUMW_W'(NW));

    always_comb begin
        rd_word = 16'h0;
        if (int'(bus.data_req_idx) < int'(num_words)) begin
            rd_word = head_pay[16*int'(bus.data_req_idx) +: 16];
        end
    end

    assign bus.event_available = !empty;
    assign bus.overflow        = head_ov;
    assign bus.data_num_words  = num_words;
    assign bus.data            = rd_word;
endmodule

// File: tb/tb_osd_event_sample_fifo.sv
// Randomized scoreboard bench: a queue-based model predicts FIFO contents, a negedge monitor reads every head word.
// A second 40-bit instance covers partial-word padding and asynchronous reset.
module tb_osd_event_sample_fifo;
    localparam int W = 64;
    localparam int D = 4;

    typedef struct {
        logic        ov;
        logic [63:0] pay;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic rst40;
    always #10 clk = ~clk;

    osd_event_sample_fifo_if #(.WIDTH(W))  bus();
    osd_event_sample_fifo_if #(.WIDTH(40)) bus40();

    osd_event_sample_fifo #(.WIDTH(W), .DEPTH(D)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    osd_event_sample_fifo #(.WIDTH(40), .DEPTH(4)) u_dut40 (
        .clk (clk),
        .rst (rst40),
        .bus (bus40.slave)
    );

    int   n_chk = 0;
    int   n_pass = 0;
    ent_t sb[$];
    int   m_cnt = 0;
    int   ov = 0;
    bit   model_on = 0;
    bit   mon_on = 0;
    int   p_cons = 0;
    logic [15:0] last_ov_word = 16'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: FIFO as a queue plus a saturating drop counter.
    always @(posedge clk) begin
        if (model_on) begin
            bit full;
            int pushed;
            int popped;
            full   = (m_cnt == D);
            pushed = 0;
            if (ov != 0 && !full) begin
                sb.push_back('{1'b1, 64'(ov)});
                ov     = bus.sample_valid ? 1 : 0;
                pushed = 1;
            end else if (bus.sample_valid && !full) begin
                sb.push_back('{1'b0, bus.sample_data});
                pushed = 1;
            end else if (bus.sample_valid) begin
                ov = (ov >= 65535) ? 65535 : ov + 1;
            end
            popped = (bus.event_consumed && m_cnt > 0) ? 1 : 0;
            m_cnt  = m_cnt + pushed - popped;
        end
    end

    // Monitor: compare head against scoreboard, then randomly consume.
    always @(negedge clk) begin
        if (mon_on) begin
            ent_t        e;
            int          nw;
            logic [15:0] ew;
            bus.event_consumed = 1'b0;
            chk("available", 64'(bus.event_available), 64'(m_cnt > 0));
            if (bus.event_available) begin
                chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e  = sb[0];
                    nw = e.ov ? 1 : 4;
                    chk("overflow", 64'(bus.overflow), 64'(e.ov));
                    chk("num_words", 64'(bus.data_num_words), 64'(nw));
                    for (int i = 0; i < 4; i++) begin
                        bus.data_req_idx = 2'(i);
                        #1;
                        ew = (i < nw) ? e.pay[16*i +: 16] : 16'h0;
                        chk("data_word", 64'(bus.data), 64'(ew));
                        if (e.ov && i == 0) last_ov_word = bus.data;
                    end
                end
            end
            if ($urandom_range(99) < p_cons) begin
                bus.event_consumed = 1'b1;
                if (bus.event_available && sb.size() > 0) void'(sb.pop_front());
            end
        end
    end

    int          ph_sv   [8] = '{30, 100, 100, 60, 100,   0, 100,   0};
    int          ph_cons [8] = '{70,   0,  40, 30,   0, 100,  90, 100};
    int          ph_len  [8] = '{400, 12, 400, 400, 66000, 100, 300, 100};
    logic [15:0] exp40   [4] = '{16'h0123, 16'hCDEF, 16'h00AB, 16'h0000};

    initial begin
        rst = 1'b1;
        rst40 = 1'b1;
        bus.sample_valid = 1'b0;   bus.sample_data = '0;   bus.event_consumed = 1'b0;
        bus.data_req_idx = '0;     bus.data_req_valid = 1'b0;
        bus40.sample_valid = 1'b0; bus40.sample_data = '0; bus40.event_consumed = 1'b0;
        bus40.data_req_idx = '0;   bus40.data_req_valid = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_available", 64'(bus.event_available), 64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);
        chk("rst_num_words", 64'(bus.data_num_words), 64'd0);
        chk("rst_data", 64'(bus.data), 64'd0);
        chk("rst40_available", 64'(bus40.event_available), 64'd0);

        // 40-bit instance: three words, top word zero-padded, index 3 reads zero.
        rst40 = 1'b0;
        @(negedge clk);
        bus40.sample_valid = 1'b1;
        bus40.sample_data  = 40'hAB_CDEF_0123;
        @(negedge clk);
        bus40.sample_valid = 1'b0;
        chk("w40_available", 64'(bus40.event_available), 64'd1);
        chk("w40_num_words", 64'(bus40.data_num_words), 64'd3);
        for (int i = 0; i < 4; i++) begin
            bus40.data_req_idx = 2'(i);
            #1;
            chk("w40_data", 64'(bus40.data), 64'(exp40[i]));
        end
        bus40.data_req_valid = 1'b1;
        @(posedge clk);
        #3 rst40 = 1'b1;
        #1;
        chk("w40_async_rst_available", 64'(bus40.event_available), 64'd0);
        chk("w40_async_rst_num_words", 64'(bus40.data_num_words), 64'd0);

        @(negedge clk);
        rst = 1'b0;
        model_on = 1;
        mon_on = 1;
        for (int p = 0; p < 8; p++) begin
            p_cons = ph_cons[p];
            for (int c = 0; c < ph_len[p]; c++) begin
                @(negedge clk);
                bus.sample_valid = ($urandom_range(99) < ph_sv[p]);
                bus.sample_data  = {$urandom, $urandom};
            end
            if (p == 5) chk("saturated_ov_word", 64'(last_ov_word), 64'hFFFF);
        end
        bus.sample_valid = 1'b0;
        p_cons = 100;
        repeat (20) @(negedge clk);
        mon_on = 0;
        @(negedge clk);
        chk("drained_scoreboard", 64'(sb.size()), 64'd0);
        chk("drained_available", 64'(bus.event_available), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
